// File: rtl/universal_register.sv
// General-purpose register: load, increment/decrement, serial shift, clear,
// and a multi-cycle rotate-left with a ready/done handshake.
module universal_register #(
  parameter int               WIDTH       = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               AW          = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] in,
  input  logic             sin,
  input  logic [AW-1:0]    amt,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             zero,
  output logic             ready,
  output logic             done
);

  localparam logic [2:0] OP_HOLD  = 3'b000;
  localparam logic [2:0] OP_LOAD  = 3'b001;
  localparam logic [2:0] OP_INC   = 3'b010;
  localparam logic [2:0] OP_DEC   = 3'b011;
  localparam logic [2:0] OP_SHL   = 3'b100;
  localparam logic [2:0] OP_SHR   = 3'b101;
  localparam logic [2:0] OP_CLEAR = 3'b110;
  localparam logic [2:0] OP_ROT   = 3'b111;

  typedef enum logic {
    S_IDLE,
    S_ROTATE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] out_q,   out_d;
  logic             carry_q, carry_d;
  logic             done_q,  done_d;
  logic [AW-1:0]    cnt_q,   cnt_d;

  function automatic logic [WIDTH-1:0] rotl1(input logic [WIDTH-1:0] v);
    return {v[WIDTH-2:0], v[WIDTH-1]};
  endfunction

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    carry_d = carry_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (en) begin
          case (op)
            OP_HOLD: ;
            OP_LOAD: begin
              out_d   = in;
              carry_d = 1'b0;
              done_d  = 1'b1;
            end
            OP_INC: begin
              out_d   = out_q + WIDTH'(1);
              carry_d = &out_q;
              done_d  = 1'b1;
            end
            OP_DEC: begin
              out_d   = out_q - WIDTH'(1);
              carry_d = (out_q == '0);
              done_d  = 1'b1;
            end
            OP_SHL: begin
              out_d   = {out_q[WIDTH-2:0], sin};
              carry_d = out_q[WIDTH-1];
              done_d  = 1'b1;
            end
            OP_SHR: begin
              out_d   = {sin, out_q[WIDTH-1:1]};
              carry_d = out_q[0];
              done_d  = 1'b1;
            end
            OP_CLEAR: begin
              out_d   = '0;
              carry_d = 1'b0;
              done_d  = 1'b1;
            end
            OP_ROT: begin
              if (amt == '0) begin
                done_d = 1'b1;
              end else begin
                // First step happens on the accepting edge; only amt>=2 needs ROTATE.
                out_d   = rotl1(out_q);
                carry_d = out_q[WIDTH-1];
                if (amt == AW'(1)) begin
                  done_d = 1'b1;
                end else begin
                  state_d = S_ROTATE;
                  cnt_d   = amt - AW'(1);
                end
              end
            end
            default: ;
          endcase
        end
      end

      S_ROTATE: begin
        out_d   = rotl1(out_q);
        carry_d = out_q[WIDTH-1];
        cnt_d   = cnt_q - AW'(1);
        if (cnt_q == AW'(1)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      out_q   <= RESET_VALUE;
      carry_q <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      carry_q <= carry_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out   = out_q;
  assign carry = carry_q;
  assign done  = done_q;
  assign zero  = (out_q == '0);
  assign ready = (state_q == S_IDLE);

endmodule

// File: tb/tb_universal_register.sv
// Scoreboard bench for universal_register: 16-bit instance with a non-zero
// reset value plus a 12-bit instance for rotate amounts beyond the width.
module tb_universal_register;

  typedef struct packed {
    logic [15:0] val;
    logic        cy;
    logic        zr;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  exp_t q16[$];
  exp_t q12[$];

  // 16-bit instance
  logic        rst16_n, en16, sin16, carry16, zero16, ready16, done16;
  logic [2:0]  op16;
  logic [15:0] in16, out16;
  logic [3:0]  amt16;

  // 12-bit instance
  logic        rst12_n, en12, sin12, carry12, zero12, ready12, done12;
  logic [2:0]  op12;
  logic [11:0] in12, out12;
  logic [3:0]  amt12;

  universal_register #(.WIDTH(16), .RESET_VALUE(16'hA5A5)) dut16 (
    .clk(clk), .reset_n(rst16_n), .en(en16), .op(op16), .in(in16), .sin(sin16),
    .amt(amt16), .out(out16), .carry(carry16), .zero(zero16), .ready(ready16),
    .done(done16)
  );

  universal_register #(.WIDTH(12), .RESET_VALUE(12'h000)) dut12 (
    .clk(clk), .reset_n(rst12_n), .en(en12), .op(op12), .in(in12), .sin(sin12),
    .amt(amt12), .out(out12), .carry(carry12), .zero(zero12), .ready(ready12),
    .done(done12)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitors: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rst16_n && done16) begin
      if (q16.size() == 0) begin
        chk("done16_unexpected", 32'(done16), 32'd0);
      end else begin
        exp_t e;
        e = q16.pop_front();
        chk("out16", 32'(out16), 32'(e.val));
        chk("carry16", 32'(carry16), 32'(e.cy));
        chk("zero16", 32'(zero16), 32'(e.zr));
        chk("ready16_at_done", 32'(ready16), 32'd1);
      end
    end
  end

  always @(negedge clk) begin
    if (rst12_n && done12) begin
      if (q12.size() == 0) begin
        chk("done12_unexpected", 32'(done12), 32'd0);
      end else begin
        exp_t e;
        e = q12.pop_front();
        chk("out12", 32'(out12), 32'(e.val));
        chk("carry12", 32'(carry12), 32'(e.cy));
        chk("zero12", 32'(zero12), 32'(e.zr));
        chk("ready12_at_done", 32'(ready12), 32'd1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue16(input logic [2:0] o, input logic [15:0] d, input logic s,
                         input logic [3:0] a);
    en16 = 1'b1; op16 = o; in16 = d; sin16 = s; amt16 = a;
    tick();
    en16 = 1'b0;
  endtask

  task automatic push16(input logic [15:0] v, input logic c);
    exp_t e;
    e.val = v; e.cy = c; e.zr = (v == 16'h0);
    q16.push_back(e);
  endtask

  initial begin
    rst16_n = 1'b0; en16 = 1'b0; op16 = 3'd0; in16 = '0; sin16 = 1'b0; amt16 = '0;
    rst12_n = 1'b0; en12 = 1'b0; op12 = 3'd0; in12 = '0; sin12 = 1'b0; amt12 = '0;
    repeat (2) tick();
    rst16_n = 1'b1;
    rst12_n = 1'b1;
    chk("rst_out", 32'(out16), 32'h0000A5A5);
    chk("rst_carry", 32'(carry16), 32'd0);
    chk("rst_ready", 32'(ready16), 32'd1);
    chk("rst_done", 32'(done16), 32'd0);

    // Load, then a mid-cycle asynchronous reset
    push16(16'h1234, 1'b0); issue16(3'b001, 16'h1234, 1'b0, 4'd0);
    @(negedge clk); #1;
    rst16_n = 1'b0;
    #1;
    chk("async_rst_out", 32'(out16), 32'h0000A5A5);
    chk("async_rst_carry", 32'(carry16), 32'd0);
    chk("async_rst_ready", 32'(ready16), 32'd1);
    tick();
    rst16_n = 1'b1;
    push16(16'h1234, 1'b0); issue16(3'b001, 16'h1234, 1'b0, 4'd0);
    tick();
    chk("load_done_one_cycle", 32'(done16), 32'd0);

    // Wrap-around
    push16(16'hFFFF, 1'b0); issue16(3'b001, 16'hFFFF, 1'b0, 4'd0);
    push16(16'h0000, 1'b1); issue16(3'b010, 16'h0, 1'b0, 4'd0);
    push16(16'hFFFF, 1'b1); issue16(3'b011, 16'h0, 1'b0, 4'd0);
    push16(16'hFFFE, 1'b0); issue16(3'b011, 16'h0, 1'b0, 4'd0);

    // Shifts and clear
    push16(16'h8001, 1'b0); issue16(3'b001, 16'h8001, 1'b0, 4'd0);
    push16(16'h0002, 1'b1); issue16(3'b100, 16'h0, 1'b0, 4'd0);
    push16(16'h8001, 1'b0); issue16(3'b101, 16'h0, 1'b1, 4'd0);
    push16(16'h0000, 1'b0); issue16(3'b110, 16'hFFFF, 1'b0, 4'd0);

    // HOLD: no done, no change
    issue16(3'b000, 16'hFFFF, 1'b1, 4'd0);
    chk("hold_done", 32'(done16), 32'd0);
    chk("hold_out", 32'(out16), 32'h0);

    // ROT by 4 with LOAD held on en while busy
    push16(16'h000F, 1'b0); issue16(3'b001, 16'h000F, 1'b0, 4'd0);
    push16(16'h00F0, 1'b0);
    en16 = 1'b1; op16 = 3'b111; amt16 = 4'd4;
    tick();
    chk("rot4_step1", 32'(out16), 32'h001E);
    chk("rot4_busy1", 32'(ready16), 32'd0);
    op16 = 3'b001; in16 = 16'hFFFF;
    tick();
    chk("rot4_step2", 32'(out16), 32'h003C);
    chk("rot4_busy2", 32'(ready16), 32'd0);
    tick();
    chk("rot4_step3", 32'(out16), 32'h0078);
    chk("rot4_busy3", 32'(ready16), 32'd0);
    tick();
    chk("rot4_step4", 32'(out16), 32'h00F0);
    chk("rot4_ready", 32'(ready16), 32'd1);
    en16 = 1'b0;
    tick();

    // ROT by 1 and by 0
    push16(16'h8000, 1'b0); issue16(3'b001, 16'h8000, 1'b0, 4'd0);
    push16(16'h0001, 1'b1); issue16(3'b111, 16'h0, 1'b0, 4'd1);
    chk("rot1_ready", 32'(ready16), 32'd1);
    push16(16'h0001, 1'b1); issue16(3'b111, 16'h0, 1'b0, 4'd0);

    // ROT by 2 followed back-to-back by a LOAD on the done cycle
    push16(16'h0004, 1'b0);
    en16 = 1'b1; op16 = 3'b111; amt16 = 4'd2;
    tick();
    chk("rot2_step1", 32'(out16), 32'h0002);
    op16 = 3'b001; in16 = 16'h5555;
    push16(16'h5555, 1'b0);
    tick();
    chk("rot2_step2", 32'(out16), 32'h0004);
    tick();
    en16 = 1'b0;
    chk("b2b_load", 32'(out16), 32'h5555);
    tick();

    // Abort a long rotation with reset
    push16(16'h0001, 1'b0); issue16(3'b001, 16'h0001, 1'b0, 4'd0);
    issue16(3'b111, 16'h0, 1'b0, 4'd10);
    tick(); tick();
    chk("abort_pre", 32'(out16), 32'h0008);
    #3;
    rst16_n = 1'b0;
    #1;
    chk("abort_out", 32'(out16), 32'h0000A5A5);
    chk("abort_ready", 32'(ready16), 32'd1);
    chk("abort_carry", 32'(carry16), 32'd0);
    tick();
    rst16_n = 1'b1;
    tick(); tick();
    chk("abort_no_done", 32'(done16), 32'd0);
    push16(16'h0F0F, 1'b0); issue16(3'b001, 16'h0F0F, 1'b0, 4'd0);
    tick();

    // 12-bit: ROT amt=13 behaves as rotate-by-1 over 13 edges
    begin
      exp_t e;
      int cyc;
      e.val = 16'h0801; e.cy = 1'b0; e.zr = 1'b0; q12.push_back(e);
      en12 = 1'b1; op12 = 3'b001; in12 = 12'h801;
      tick();
      e.val = 16'h0003; e.cy = 1'b1; e.zr = 1'b0; q12.push_back(e);
      op12 = 3'b111; amt12 = 4'd13;
      tick();
      en12 = 1'b0;
      cyc = 0;
      while (!ready12 && cyc < 40) begin
        tick();
        cyc++;
      end
      chk("rot13_busy_cycles", 32'(cyc), 32'd12);
      chk("rot13_out", 32'(out12), 32'h003);
      tick();
    end

    repeat (3) tick();
    chk("q16_drained", 32'(q16.size()), 32'd0);
    chk("q12_drained", 32'(q12.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
